push_button_conditioner: RTL and testbench



---
 rtl/push_button_conditioner.sv | 179 +++++++++++++++++
 tb/tb_push_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_conditioner.sv
// -----------------------------------------------------------------------------
// push_button_conditioner
//
// Turns raw, bouncing push-button pins into clean control signals. Each
// channel is handled independently:
//   polarity normalisation -> 2-flop synchroniser -> debouncer -> press FSM
//
// The press FSM emits a one-cycle strobe on the debounced press and, when
// REPEAT_EN is set, further strobes while the button stays held.
//
// Ports
//   clk          system clock (single clock domain)
//   rst          synchronous reset, active-low
//   buttons_raw  asynchronous button pins, one bit per channel
//   pulse_out    one-cycle press / repeat strobes, active-high
//   level_out    debounced pressed state, active-high
//   held_out     high once a button has been held for HOLD_CYCLES cycles
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module push_button_conditioner #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW_IN   = 1,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] pulse_out,
    output logic [N_BUTTONS-1:0] level_out,
    output logic [N_BUTTONS-1:0] held_out
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } press_state_t;

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;
    // A single hold counter serves both the initial hold and the repeat period.
    localparam int H_W    = (HOLD_W > REP_W) ? HOLD_W : REP_W;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [H_W-1:0]  HOLD_LAST = H_W'(HOLD_CYCLES - 1);
    localparam logic [H_W-1:0]  REP_LAST  = H_W'(REPEAT_CYCLES - 1);
    localparam logic            REP_PULSE = (REPEAT_EN != 0);

    // After this, 1 always means "pressed" regardless of board wiring.
    logic [N_BUTTONS-1:0] pressed_norm;
    assign pressed_norm = (ACTIVE_LOW_IN != 0) ? ~buttons_raw : buttons_raw;

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
            logic            sync1_reg;
            logic            sync2_reg;
            logic [DB_W-1:0] db_cnt_reg;
            logic [DB_W-1:0] db_cnt_next;
            logic            db_level_reg;
            logic            db_level_next;
            logic            level_reg;
            press_state_t    state_reg;
            press_state_t    state_next;
            logic [H_W-1:0]  h_cnt_reg;
            logic [H_W-1:0]  h_cnt_next;
            logic            pulse_reg;
            logic            pulse_next;
            logic            held_reg;
            logic            held_next;
            logic            rise;
            logic            fall;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    db_cnt_reg   <= '0;
                    db_level_reg <= 1'b0;
                    level_reg    <= 1'b0;
                    state_reg    <= IDLE;
                    h_cnt_reg    <= '0;
                    pulse_reg    <= 1'b0;
                    held_reg     <= 1'b0;
                end else begin
                    sync1_reg    <= pressed_norm[gi];
                    sync2_reg    <= sync1_reg;
                    db_cnt_reg   <= db_cnt_next;
                    db_level_reg <= db_level_next;
                    level_reg    <= db_level_reg;
                    state_reg    <= state_next;
                    h_cnt_reg    <= h_cnt_next;
                    pulse_reg    <= pulse_next;
                    held_reg     <= held_next;
                end
            end

            // Debounce: count consecutive cycles in which the synchronised
            // level disagrees with the accepted level. Any agreement restarts
            // the count, so bounces never accumulate.
            always_comb begin
                db_cnt_next   = '0;
                db_level_next = db_level_reg;
                if (sync2_reg != db_level_reg) begin
                    if (db_cnt_reg == DB_LAST) begin
                        db_level_next = sync2_reg;
                    end else begin
                        db_cnt_next = db_cnt_reg + DB_W'(1);
                    end
                end
            end

            // level_reg trails db_level_reg by one cycle, so their difference
            // marks the debounced edges. level_out and pulse_out therefore
            // change on the same clock edge.
            assign rise = db_level_reg & ~level_reg;
            assign fall = ~db_level_reg & level_reg;

            always_comb begin
                state_next = state_reg;
                h_cnt_next = h_cnt_reg;
                pulse_next = 1'b0;
                held_next  = held_reg;
                case (state_reg)
                    IDLE: begin
                        if (rise) begin
                            state_next = PRESSED;
                            h_cnt_next = '0;
                            pulse_next = 1'b1;
                            held_next  = 1'b0;
                        end
                    end
                    PRESSED: begin
                        if (fall) begin
                            state_next = IDLE;
                            h_cnt_next = '0;
                            held_next  = 1'b0;
                        end else if (h_cnt_reg == HOLD_LAST) begin
                            state_next = REPEAT;
                            h_cnt_next = '0;
                            held_next  = 1'b1;
                            pulse_next = REP_PULSE;
                        end else begin
                            h_cnt_next = h_cnt_reg + H_W'(1);
                        end
                    end
                    REPEAT: begin
                        // A release takes precedence over a coincident
                        // repeat terminal count, so no pulse is emitted.
                        if (fall) begin
                            state_next = IDLE;
                            h_cnt_next = '0;
                            held_next  = 1'b0;
                        end else if (h_cnt_reg == REP_LAST) begin
                            h_cnt_next = '0;
                            pulse_next = REP_PULSE;
                        end else begin
                            h_cnt_next = h_cnt_reg + H_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        h_cnt_next = '0;
                        held_next  = 1'b0;
                    end
                endcase
            end

            assign pulse_out[gi] = pulse_reg;
            assign level_out[gi] = level_reg;
            assign held_out[gi]  = held_reg;
        end
    endgenerate

endmodule

// File: tb/tb_push_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_push_button_conditioner
//
// Two instances are driven with the same stimulus: one with auto-repeat and
// one without. A behavioural model derives the expected outputs directly from
// the stream of sampled inputs:
//   - A level is accepted once DEBOUNCE_CYCLES consecutive synchronised
//     samples all disagree with the current level.
//   - Pulses and the held flag follow from the elapsed time since the press.
// Expected pulses are placed in queues. A monitor pops an entry whenever a DUT
// raises pulse_out and compares it. It also compares level_out and held_out
// on every cycle.
// -----------------------------------------------------------------------------
module tb_push_button_conditioner;

    localparam int N = 3;
    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] buttons_raw = '1;
    logic [N-1:0] pulse_r, level_r, held_r;
    logic [N-1:0] pulse_n, level_n, held_n;

    push_button_conditioner #(
        .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1),
        .REPEAT_EN(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut_rep (
        .clk(clk), .rst(rst), .buttons_raw(buttons_raw),
        .pulse_out(pulse_r), .level_out(level_r), .held_out(held_r)
    );

    push_button_conditioner #(
        .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1),
        .REPEAT_EN(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut_norep (
        .clk(clk), .rst(rst), .buttons_raw(buttons_raw),
        .pulse_out(pulse_n), .level_out(level_n), .held_out(held_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int           cyc;
        logic [N-1:0] vec;
    } pulse_t;

    pulse_t       exp_q_rep[$];
    pulse_t       exp_q_norep[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [N-1:0] exp_level = '0;
    logic [N-1:0] exp_held  = '0;

    // Model state
    logic [N-1:0] pipe1 = '0;  // input delayed by one sample
    logic [N-1:0] pipe2 = '0;  // input delayed by two samples
    logic [N-1:0] accepted = '0;
    logic [N-1:0] hist [D];
    int           press_edge [N];

    task automatic model_step();
        logic [N-1:0] seen;
        logic [N-1:0] lvl_new;
        logic [N-1:0] p_rep;
        logic [N-1:0] p_norep;
        logic [N-1:0] held_new;
        logic         all_diff;
        int           d;
        cyc++;
        if (!rst) begin
            pipe1     = '0;
            pipe2     = '0;
            accepted  = '0;
            for (int i = 0; i < D; i++) hist[i] = '0;
            exp_level = '0;
            exp_held  = '0;
        end else begin
            seen  = pipe2;
            pipe2 = pipe1;
            pipe1 = ~buttons_raw;
            for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = seen;
            lvl_new  = accepted;
            p_rep    = '0;
            p_norep  = '0;
            held_new = '0;
            for (int ch = 0; ch < N; ch++) begin
                if (lvl_new[ch] && !exp_level[ch]) begin
                    press_edge[ch] = cyc;
                    p_rep[ch]      = 1'b1;
                    p_norep[ch]    = 1'b1;
                end else if (lvl_new[ch]) begin
                    d = cyc - press_edge[ch];
                    held_new[ch] = (d >= H);
                    if (d == H || (d > H && ((d - H) % R) == 0)) p_rep[ch] = 1'b1;
                end
            end
            for (int ch = 0; ch < N; ch++) begin
                all_diff = 1'b1;
                for (int i = 0; i < D; i++)
                    if (hist[i][ch] == accepted[ch]) all_diff = 1'b0;
                if (all_diff) accepted[ch] = ~accepted[ch];
            end
            exp_level = lvl_new;
            exp_held  = held_new;
            if (p_rep != '0)   exp_q_rep.push_back('{cyc: cyc, vec: p_rep});
            if (p_norep != '0) exp_q_norep.push_back('{cyc: cyc, vec: p_norep});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor
    initial begin
        pulse_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                // dut_rep pulses
                while (exp_q_rep.size() > 0 && exp_q_rep[0].cyc < cyc) begin
                    e = exp_q_rep.pop_front();
                    total++; bad++;
                    $display("FAIL pulse_rep_missing cycle=%0d actual=none required=%b@%0d", cyc, e.vec, e.cyc);
                end
                if (pulse_r != '0) begin
                    total++;
                    if (exp_q_rep.size() == 0) begin
                        bad++;
                        $display("FAIL pulse_rep_unexpected cycle=%0d actual=%b required=none", cyc, pulse_r);
                    end else begin
                        e = exp_q_rep.pop_front();
                        if (e.cyc != cyc || e.vec != pulse_r) begin
                            bad++;
                            $display("FAIL pulse_rep cycle=%0d actual=%b required=%b@%0d", cyc, pulse_r, e.vec, e.cyc);
                        end
                    end
                end
                // dut_norep pulses
                while (exp_q_norep.size() > 0 && exp_q_norep[0].cyc < cyc) begin
                    e = exp_q_norep.pop_front();
                    total++; bad++;
                    $display("FAIL pulse_norep_missing cycle=%0d actual=none required=%b@%0d", cyc, e.vec, e.cyc);
                end
                if (pulse_n != '0) begin
                    total++;
                    if (exp_q_norep.size() == 0) begin
                        bad++;
                        $display("FAIL pulse_norep_unexpected cycle=%0d actual=%b required=none", cyc, pulse_n);
                    end else begin
                        e = exp_q_norep.pop_front();
                        if (e.cyc != cyc || e.vec != pulse_n) begin
                            bad++;
                            $display("FAIL pulse_norep cycle=%0d actual=%b required=%b@%0d", cyc, pulse_n, e.vec, e.cyc);
                        end
                    end
                end
                total += 4;
                if (level_r !== exp_level) begin
                    bad++;
                    $display("FAIL level_rep cycle=%0d actual=%b required=%b", cyc, level_r, exp_level);
                end
                if (level_n !== exp_level) begin
                    bad++;
                    $display("FAIL level_norep cycle=%0d actual=%b required=%b", cyc, level_n, exp_level);
                end
                if (held_r !== exp_held) begin
                    bad++;
                    $display("FAIL held_rep cycle=%0d actual=%b required=%b", cyc, held_r, exp_held);
                end
                if (held_n !== exp_held) begin
                    bad++;
                    $display("FAIL held_norep cycle=%0d actual=%b required=%b", cyc, held_n, exp_held);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt [N];
        // Reset held for 3 edges with all buttons released, then 20 quiet cycles
        rst = 1'b0;
        buttons_raw = '1;
        idle(3);
        rst = 1'b1;
        $display("txn reset_release cycle=%0d", cyc);
        idle(20);

        // Clean press on button 0
        $display("txn clean_press btn0 cycle=%0d", cyc);
        buttons_raw[0] = 1'b0; idle(8);
        buttons_raw[0] = 1'b1; idle(12);

        // Bouncing button 1, then settled pressed
        $display("txn bounce btn1 cycle=%0d", cyc);
        for (int i = 0; i < 10; i++) begin
            buttons_raw[1] = i[0];
            idle(2);
        end
        buttons_raw[1] = 1'b0; idle(12);
        buttons_raw[1] = 1'b1; idle(12);

        // Long hold on button 2 exercising hold and repeat
        $display("txn long_hold btn2 cycle=%0d", cyc);
        buttons_raw[2] = 1'b0; idle(30);
        buttons_raw[2] = 1'b1; idle(12);

        // All three pressed on the same edge
        $display("txn simultaneous cycle=%0d", cyc);
        buttons_raw = '0; idle(6);
        buttons_raw = '1; idle(12);

        // Reset while button 0 is in the repeat phase, still held afterwards
        $display("txn reset_mid_hold btn0 cycle=%0d", cyc);
        buttons_raw[0] = 1'b0; idle(22);
        rst = 1'b0; idle(2);
        rst = 1'b1; idle(15);
        buttons_raw[0] = 1'b1; idle(12);

        // Random activity: per-channel runs of random length, rare resets
        $display("txn random_start cycle=%0d", cyc);
        for (int ch = 0; ch < N; ch++) cnt[ch] = $urandom_range(1, 40);
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (cnt[ch] == 0) begin
                    buttons_raw[ch] = ~buttons_raw[ch];
                    cnt[ch] = $urandom_range(1, 40);
                end else begin
                    cnt[ch]--;
                end
            end
            rst = ($urandom_range(0, 499) != 0);
            idle(1);
        end
        rst = 1'b1;
        buttons_raw = '1;
        idle(40);
        $display("txn random_end cycle=%0d", cyc);

        total += 2;
        if (exp_q_rep.size() != 0) begin
            bad++;
            $display("FAIL pulse_rep_leftover actual=%0d_outstanding required=0", exp_q_rep.size());
        end
        if (exp_q_norep.size() != 0) begin
            bad++;
            $display("FAIL pulse_norep_leftover actual=%0d_outstanding required=0", exp_q_norep.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
